// File: rtl/multdiv_ctrl_if.sv
// ---------------------------------------------------------------------------
// multdiv_ctrl_if
//
// Groups every signal that passes between the execute-stage mul/div sequencer
// and its neighbours: the X stage (decode inputs, flush), the shared
// multi-cycle multiplier/divider, the pipeline stall/busy lines and the
// writeback request into the X/M latch.
//
// Handshake semantics, as seen from the sequencer:
//   x_valid qualifies x_op/x_aluop/x_rd/x_a/x_b in the same cycle. A mul/div
//   is taken only while the sequencer is idle; stall tells the X stage to hold
//   its instruction. md_mult/md_div are one-cycle start pulses that qualify
//   md_a/md_b; md_a/md_b stay stable until the next accepted op. md_ready
//   qualifies md_result/md_exception for exactly the cycle it is high.
//   wb_valid qualifies wb_rd/wb_data for one cycle; there is no back-pressure.
//
// Modports:
//   slave  - the sequencer (multdiv_ctrl)
//   master - the environment driving X-stage and unit-response signals
//
// Parameter:
//   WIDTH - operand/result width
// ---------------------------------------------------------------------------
interface multdiv_ctrl_if #(
    parameter int WIDTH = 32
);
    // X stage
    logic             x_valid;
    logic [4:0]       x_op;
    logic [4:0]       x_aluop;
    logic [4:0]       x_rd;
    logic [WIDTH-1:0] x_a;
    logic [WIDTH-1:0] x_b;
    logic             flush;

    // Multiplier/divider unit
    logic             md_mult;
    logic             md_div;
    logic [WIDTH-1:0] md_a;
    logic [WIDTH-1:0] md_b;
    logic [WIDTH-1:0] md_result;
    logic             md_exception;
    logic             md_ready;

    // Pipeline control and writeback
    logic             stall;
    logic             busy;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;

    modport slave (
        input  x_valid, x_op, x_aluop, x_rd, x_a, x_b, flush,
        input  md_result, md_exception, md_ready,
        output md_mult, md_div, md_a, md_b,
        output stall, busy, wb_valid, wb_rd, wb_data
    );

    modport master (
        output x_valid, x_op, x_aluop, x_rd, x_a, x_b, flush,
        output md_result, md_exception, md_ready,
        input  md_mult, md_div, md_a, md_b,
        input  stall, busy, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// ---------------------------------------------------------------------------
// multdiv_ctrl
//
// Execute-stage sequencer for the shared multi-cycle multiplier/divider.
// Decodes R-type mul/div in X, launches the unit with a one-cycle start pulse,
// stalls F/D/X while the unit works, and produces exactly one writeback:
// either the product/quotient to rd, or an exception code to $rstatus (r30)
// (4 for multiply overflow, 5 for divide exception).
//
// Ports:
//   clock        - rising-edge clock
//   reset        - synchronous, active-low reset
//   bus          - multdiv_ctrl_if.slave (X stage, unit, stall, writeback)
//   o_dbg_state  - current FSM state (0 IDLE, 1 LAUNCH, 2 BUSY, 3 DONE)
//
// Parameters:
//   WIDTH          - operand/result width
//   TIMEOUT_CYCLES - BUSY-cycle watchdog limit (only with MULTDIV_TIMEOUT_EN)
//
// Optional build macro:
//   MULTDIV_TIMEOUT_EN - when defined, a watchdog counts BUSY cycles and forces
//                        an exception writeback after TIMEOUT_CYCLES without
//                        md_ready. When undefined, BUSY waits indefinitely.
// ---------------------------------------------------------------------------
module multdiv_ctrl #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic               clock,
    input  logic               reset,
    multdiv_ctrl_if.slave      bus,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [4:0]       OP_RTYPE  = 5'b00000;
    localparam logic [4:0]       ALU_MULT  = 5'b00110;
    localparam logic [4:0]       ALU_DIV   = 5'b00111;
    localparam logic [4:0]       REG_RSTAT = 5'd30;
    localparam logic [WIDTH-1:0] CODE_MULT = WIDTH'(4);
    localparam logic [WIDTH-1:0] CODE_DIV  = WIDTH'(5);

    state_t           r_state;
    logic             r_md_mult;
    logic             r_md_div;
    logic [WIDTH-1:0] r_md_a;
    logic [WIDTH-1:0] r_md_b;
    logic             r_kind_div;
    logic [4:0]       r_rd;
    logic             r_busy;
    logic             r_stall_hold;
    logic             r_wb_valid;
    logic [4:0]       r_wb_rd;
    logic [WIDTH-1:0] r_wb_data;

    logic             w_is_mult;
    logic             w_is_div;
    logic             w_accept;
    logic             w_timeout;

    // ------------------------------------------------------------------
    // Decode. is_mult and is_div are mutually exclusive by construction,
    // so at most one start pulse can ever be raised.
    // Gating accept with reset keeps stall low while reset is held.
    // ------------------------------------------------------------------
    assign w_is_mult = (bus.x_op == OP_RTYPE) && (bus.x_aluop == ALU_MULT);
    assign w_is_div  = (bus.x_op == OP_RTYPE) && (bus.x_aluop == ALU_DIV);
    assign w_accept  = reset && bus.x_valid && (w_is_mult || w_is_div) &&
                       !bus.flush && (r_state == S_IDLE);

    // ------------------------------------------------------------------
    // Optional BUSY watchdog
    // ------------------------------------------------------------------
`ifdef MULTDIV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_to_cnt;

    // Counts completed BUSY cycles; cleared as the op enters LAUNCH so every
    // operation gets a full budget.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_to_cnt <= '0;
        end else if (w_accept) begin
            r_to_cnt <= '0;
        end else if (r_state == S_BUSY) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Fires in the TIMEOUT_CYCLES-th BUSY cycle; md_ready in that same cycle
    // still takes priority in the FSM.
    assign w_timeout = (r_state == S_BUSY) &&
                       (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM. All outputs except stall (which must react to a
    // same-cycle accept) and wb_valid (which must react to a same-cycle
    // flush) come straight from registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_md_mult    <= 1'b0;
            r_md_div     <= 1'b0;
            r_md_a       <= '0;
            r_md_b       <= '0;
            r_kind_div   <= 1'b0;
            r_rd         <= '0;
            r_busy       <= 1'b0;
            r_stall_hold <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
        end else begin
            // Start pulses and the writeback strobe last exactly one cycle.
            r_md_mult  <= 1'b0;
            r_md_div   <= 1'b0;
            r_wb_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state      <= S_LAUNCH;
                        r_md_a       <= bus.x_a;
                        r_md_b       <= bus.x_b;
                        r_rd         <= bus.x_rd;
                        r_kind_div   <= w_is_div;
                        r_md_mult    <= w_is_mult;
                        r_md_div     <= w_is_div;
                        r_busy       <= 1'b1;
                        r_stall_hold <= 1'b1;
                    end
                end

                // md_ready is deliberately not looked at here: the unit has
                // only just seen the start pulse.
                S_LAUNCH: begin
                    if (bus.flush) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_stall_hold <= 1'b0;
                    end else begin
                        r_state <= S_BUSY;
                    end
                end

                // Flush beats a simultaneous md_ready; the abandoned result
                // (and any later md_ready) is ignored because IDLE does not
                // look at md_ready.
                S_BUSY: begin
                    if (bus.flush) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_stall_hold <= 1'b0;
                    end else if (bus.md_ready || w_timeout) begin
                        r_state      <= S_DONE;
                        r_stall_hold <= 1'b0;
                        r_wb_valid   <= 1'b1;
                        if (!bus.md_ready || bus.md_exception) begin
                            r_wb_rd   <= REG_RSTAT;
                            r_wb_data <= r_kind_div ? CODE_DIV : CODE_MULT;
                        end else begin
                            r_wb_rd   <= r_rd;
                            r_wb_data <= bus.md_result;
                        end
                    end
                end

                // The X instruction is still the completing op, so nothing is
                // accepted here even though stall has dropped.
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_stall_hold <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.md_mult  = r_md_mult;
    assign bus.md_div   = r_md_div;
    assign bus.md_a     = r_md_a;
    assign bus.md_b     = r_md_b;
    assign bus.busy     = r_busy;
    assign bus.stall    = w_accept || r_stall_hold;
    assign bus.wb_valid = r_wb_valid && !bus.flush;
    assign bus.wb_rd    = r_wb_rd;
    assign bus.wb_data  = r_wb_data;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multdiv_ctrl
//
// Directed bench for multdiv_ctrl. A behavioural model tracks the single
// in-flight operation by its age in cycles and predicts stall/busy/start
// pulses/operands/writeback every cycle; a scoreboard queue holds the
// hand-computed writebacks each scenario must produce.
// ---------------------------------------------------------------------------
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  dbg_state;

    always #5 clock = ~clock;

    multdiv_ctrl_if #(.WIDTH(32)) bus ();

    multdiv_ctrl #(.WIDTH(32), .TIMEOUT_CYCLES(40)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [36:0] exp_q[$];   // {wb_rd, wb_data}

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- model state ----------------
    bit          chk_en = 1'b0;
    bit          m_active = 1'b0;
    bit          m_done   = 1'b0;
    int          m_age    = 0;
    bit          m_div    = 1'b0;
    logic [4:0]  m_rd     = '0;
    logic [31:0] m_a      = '0;
    logic [31:0] m_b      = '0;
    logic [31:0] m_res    = '0;
    bit          m_exc    = 1'b0;

    // monitor statistics, read as deltas by the stimulus process
    int          cyc = 0;
    int          cnt_stall = 0;
    int          cnt_mult = 0;
    int          cnt_div = 0;
    int          cnt_wb = 0;
    int          last_mult_cyc = 0;
    int          last_wb_cyc = 0;
    logic [4:0]  last_wb_rd = '0;
    logic [31:0] last_wb_data = '0;

`ifdef MULTDIV_TIMEOUT_EN
    localparam int TO_LIMIT = 40;
`endif

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        if (chk_en) begin
            bit          acc;
            bit          e_wbv;
            logic [4:0]  e_rd;
            logic [31:0] e_data;

            acc = reset && bus.x_valid && (bus.x_op == 5'd0) &&
                  (bus.x_aluop == 5'd6 || bus.x_aluop == 5'd7) &&
                  !bus.flush && !m_active;
            e_wbv  = m_active && m_done && !bus.flush;
            e_rd   = m_exc ? 5'd30 : m_rd;
            e_data = m_exc ? (m_div ? 32'd5 : 32'd4) : m_res;

            chk("stall",   64'(bus.stall),   64'(acc || (m_active && !m_done)));
            chk("busy",    64'(bus.busy),    64'(m_active));
            chk("md_mult", 64'(bus.md_mult), 64'(m_active && m_age == 1 && !m_div));
            chk("md_div",  64'(bus.md_div),  64'(m_active && m_age == 1 && m_div));
            chk("md_a",    64'(bus.md_a),    64'(m_a));
            chk("md_b",    64'(bus.md_b),    64'(m_b));
            chk("wb_valid", 64'(bus.wb_valid), 64'(e_wbv));
            if (e_wbv && bus.wb_valid) begin
                chk("wb_rd",   64'(bus.wb_rd),   64'(e_rd));
                chk("wb_data", 64'(bus.wb_data), 64'(e_data));
            end

            // scoreboard against the hand-computed writeback list
            if (bus.wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_wb", 64'(bus.wb_valid), 64'(0));
                end else begin
                    logic [36:0] e;
                    e = exp_q.pop_front();
                    chk("sb_wb", 64'({bus.wb_rd, bus.wb_data}), 64'(e));
                end
            end

            // statistics
            cyc++;
            if (bus.stall)   cnt_stall++;
            if (bus.md_mult) begin cnt_mult++; last_mult_cyc = cyc; end
            if (bus.md_div)  cnt_div++;
            if (bus.wb_valid) begin
                cnt_wb++;
                last_wb_cyc  = cyc;
                last_wb_rd   = bus.wb_rd;
                last_wb_data = bus.wb_data;
            end

            // advance the model to the next cycle
            if (!reset) begin
                m_active = 1'b0;
                m_done   = 1'b0;
                m_a      = '0;
                m_b      = '0;
            end else if (m_active) begin
                if (m_done || bus.flush) begin
                    m_active = 1'b0;
                end else if (m_age >= 2 && bus.md_ready) begin
                    m_done = 1'b1;
                    m_res  = bus.md_result;
                    m_exc  = bus.md_exception;
                end
`ifdef MULTDIV_TIMEOUT_EN
                else if (m_age >= 2 && (m_age - 1) == TO_LIMIT) begin
                    m_done = 1'b1;
                    m_exc  = 1'b1;
                end
`endif
                m_age++;
            end else if (acc) begin
                m_active = 1'b1;
                m_done   = 1'b0;
                m_age    = 1;
                m_div    = (bus.x_aluop == 5'd7);
                m_rd     = bus.x_rd;
                m_a      = bus.x_a;
                m_b      = bus.x_b;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.x_valid      = 1'b0;
        bus.x_op         = 5'd0;
        bus.x_aluop      = 5'd0;
        bus.x_rd         = 5'd0;
        bus.x_a          = '0;
        bus.x_b          = '0;
        bus.flush        = 1'b0;
        bus.md_result    = '0;
        bus.md_exception = 1'b0;
        bus.md_ready     = 1'b0;
    endtask

    task automatic present(input bit div, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
        bus.x_valid = 1'b1;
        bus.x_op    = 5'd0;
        bus.x_aluop = div ? 5'd7 : 5'd6;
        bus.x_rd    = rd;
        bus.x_a     = a;
        bus.x_b     = b;
    endtask

    // Runs one op from IDLE; md_ready arrives in the n_busy-th BUSY cycle.
    // Returns positioned in the DONE cycle.
    task automatic do_op(input bit div, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int n_busy, input bit exc,
                         input logic [31:0] res);
        present(div, a, b, rd);
        tick();                       // LAUNCH
        tick();                       // BUSY 1
        repeat (n_busy - 1) tick();
        bus.md_ready     = 1'b1;
        bus.md_result    = res;
        bus.md_exception = exc;
        tick();                       // DONE
        bus.md_ready     = 1'b0;
        bus.md_exception = 1'b0;
        bus.x_valid      = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int b_stall, b_mult, b_div, b_wb, save_wb;

        reset = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clock);
        #1;
        reset  = 1'b1;
        chk_en = 1'b1;

        // reset state
        chk("rst_state",   64'(dbg_state),   64'(0));
        chk("rst_wb_rd",   64'(bus.wb_rd),   64'(0));
        chk("rst_wb_data", 64'(bus.wb_data), 64'(0));
        tick();

        // 1: mul 6*7 -> r3, ready in 5th BUSY cycle
        b_stall = cnt_stall; b_mult = cnt_mult; b_wb = cnt_wb;
        exp_q.push_back({5'd3, 32'd42});
        do_op(1'b0, 32'd6, 32'd7, 5'd3, 5, 1'b0, 32'd42);
        tick();
        chk("t1_stall_cycles", 64'(cnt_stall - b_stall), 64'(7));
        chk("t1_mult_pulses",  64'(cnt_mult - b_mult),   64'(1));
        chk("t1_wb_count",     64'(cnt_wb - b_wb),       64'(1));
        chk("t1_wb_rd",        64'(last_wb_rd),          64'(3));
        chk("t1_wb_data",      64'(last_wb_data),        64'(42));

        // 2: div 1/0 -> exception, written to r30 with code 5
        b_div = cnt_div;
        exp_q.push_back({5'd30, 32'd5});
        do_op(1'b1, 32'd1, 32'd0, 5'd4, 2, 1'b1, 32'd0);
        tick();
        chk("t2_div_pulses", 64'(cnt_div - b_div), 64'(1));
        chk("t2_wb_rd",      64'(last_wb_rd),      64'(30));
        chk("t2_wb_data",    64'(last_wb_data),    64'(5));

        // 3: mul overflow, fastest completion (DONE two cycles after pulse)
        exp_q.push_back({5'd30, 32'd4});
        do_op(1'b0, 32'h4000_0000, 32'd4, 5'd7, 1, 1'b1, 32'd0);
        tick();
        chk("t3_wb_rd",    64'(last_wb_rd),                  64'(30));
        chk("t3_wb_data",  64'(last_wb_data),                64'(4));
        chk("t3_latency",  64'(last_wb_cyc - last_mult_cyc), 64'(2));

        // 4: flush in 3rd BUSY cycle, md_ready two cycles later
        b_stall = cnt_stall; b_wb = cnt_wb;
        present(1'b0, 32'd3, 32'd3, 5'd5);
        tick(); tick(); tick(); tick();            // LAUNCH, B1, B2, B3
        bus.flush = 1'b1; bus.x_valid = 1'b0;
        tick();
        bus.flush = 1'b0;
        chk("t4_stall_after_flush", 64'(bus.stall), 64'(0));
        tick();
        bus.md_ready = 1'b1; bus.md_result = 32'd9;
        tick();
        bus.md_ready = 1'b0;
        tick(); tick();
        chk("t4_no_wb",        64'(cnt_wb - b_wb),       64'(0));
        chk("t4_stall_cycles", 64'(cnt_stall - b_stall), 64'(5));

        // 5: flush in IDLE suppresses accept
        b_mult = cnt_mult; b_stall = cnt_stall;
        present(1'b0, 32'd2, 32'd2, 5'd6);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0; bus.x_valid = 1'b0;
        tick();
        chk("t5_no_pulse", 64'(cnt_mult - b_mult),   64'(0));
        chk("t5_no_stall", 64'(cnt_stall - b_stall), 64'(0));

        // 6: flush during DONE kills the writeback
        b_wb = cnt_wb;
        do_op(1'b0, 32'd2, 32'd3, 5'd6, 1, 1'b0, 32'd6);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
        chk("t6_no_wb", 64'(cnt_wb - b_wb), 64'(0));

        // 7: md_ready and flush together in BUSY: flush wins
        b_wb = cnt_wb;
        present(1'b0, 32'd5, 32'd5, 5'd7);
        tick(); tick();                             // LAUNCH, B1
        bus.md_ready = 1'b1; bus.md_result = 32'd25;
        bus.flush = 1'b1; bus.x_valid = 1'b0;
        tick();
        bus.md_ready = 1'b0; bus.flush = 1'b0;
        tick(); tick();
        chk("t7_no_wb", 64'(cnt_wb - b_wb), 64'(0));

        // 8: reset mid-BUSY abandons the op
        b_wb = cnt_wb;
        present(1'b0, 32'd11, 32'd12, 5'd8);
        tick(); tick(); tick();                     // LAUNCH, B1, B2
        reset = 1'b0; bus.x_valid = 1'b0;
        tick();
        reset = 1'b1;
        chk("t8_state", 64'(dbg_state),   64'(0));
        chk("t8_busy",  64'(bus.busy),    64'(0));
        chk("t8_stall", 64'(bus.stall),   64'(0));
        chk("t8_md_a",  64'(bus.md_a),    64'(0));
        chk("t8_wb_rd", 64'(bus.wb_rd),   64'(0));
        tick();
        bus.md_ready = 1'b1; bus.md_result = 32'd132;
        tick();
        bus.md_ready = 1'b0;
        tick(); tick();
        chk("t8_no_wb", 64'(cnt_wb - b_wb), 64'(0));

        // 9: back-to-back multiplies
        b_wb = cnt_wb;
        exp_q.push_back({5'd9,  32'd20});
        exp_q.push_back({5'd10, 32'd56});
        do_op(1'b0, 32'd4, 32'd5, 5'd9, 2, 1'b0, 32'd20);
        tick();
        save_wb = last_wb_cyc;
        do_op(1'b0, 32'd7, 32'd8, 5'd10, 3, 1'b0, 32'd56);
        tick();
        chk("t9_wb_count",  64'(cnt_wb - b_wb),          64'(2));
        chk("t9_next_start", 64'(last_mult_cyc - save_wb), 64'(2));
        chk("t9_wb_data",   64'(last_wb_data),           64'(56));

        // 10: md_ready during LAUNCH is ignored
        exp_q.push_back({5'd11, 32'd6});
        present(1'b1, 32'd20, 32'd3, 5'd11);
        tick();                                     // LAUNCH
        bus.md_ready = 1'b1; bus.md_result = 32'd99;
        tick();                                     // B1
        bus.md_ready = 1'b0;
        tick();                                     // B2
        bus.md_ready = 1'b1; bus.md_result = 32'd6;
        tick();                                     // DONE
        bus.md_ready = 1'b0; bus.x_valid = 1'b0;
        tick();
        chk("t10_wb_data", 64'(last_wb_data), 64'(6));

`ifdef MULTDIV_TIMEOUT_EN
        // 11: watchdog forces an exception writeback after 40 BUSY cycles
        exp_q.push_back({5'd30, 32'd4});
        present(1'b0, 32'd1, 32'd1, 5'd12);
        tick();
        bus.x_valid = 1'b0;
        repeat (50) tick();
        chk("t11_to_latency", 64'(last_wb_cyc - last_mult_cyc), 64'(41));
        chk("t11_wb_rd",      64'(last_wb_rd),                  64'(30));
        chk("t11_wb_data",    64'(last_wb_data),                64'(4));
`endif

        tick();
        chk("sb_leftover", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Execute-stage sequencer for the shared multi-cycle multiplier/divider.
- Decodes R-type mul/div in X, launches the unit with a one-cycle start pulse, and stalls the pipeline until the unit is ready.
- Produces a single writeback: either the product/quotient to rd, or the overflow/exception status code to $rstatus (r30).
- Sits between the X stage, the multdiv unit and the X/M latch write-select logic.

Parameters:
- WIDTH, 32, operand/result width.
- TIMEOUT_CYCLES, 40, watchdog limit in BUSY cycles (used only with the optional feature).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- x_valid  in  1  X-stage instruction valid
- x_op  in  5  opcode
- x_aluop  in  5  ALU op field
- x_rd  in  5  destination register
- x_a, x_b  in  WIDTH  operands
- flush  in  1  kill X-stage and in-flight op (branch/jump taken)
- md_mult  out  1  start-multiply pulse to unit
- md_div  out  1  start-divide pulse to unit
- md_a, md_b  out  WIDTH  latched operands to unit
- md_result  in  WIDTH  unit result
- md_exception  in  1  unit overflow / divide-by-zero
- md_ready  in  1  unit result valid
- stall  out  1  freeze F/D/X
- busy  out  1  operation in flight
- wb_valid  out  1  writeback strobe
- wb_rd  out  5  writeback register
- wb_data  out  WIDTH  writeback value

Behaviour:
- Decode:
  - is_mult = (x_op==00000) & (x_aluop==00110).
  - is_div = (x_op==00000) & (x_aluop==00111).
  - accept = x_valid & (is_mult|is_div) & ~flush & state==IDLE.
- States: IDLE, LAUNCH, BUSY, DONE.
- Reset (reset==0 at a clock edge):
  - state=IDLE.
  - All outputs 0; md_a/md_b/wb_data/wb_rd cleared.
  - Reset mid-operation abandons the op; a later md_ready is ignored.
- IDLE:
  - stall = accept (combinational).
  - On accept: latch x_a, x_b, x_rd and kind (mult/div); go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - md_mult or md_div =1 per kind, registered, never both.
  - stall=1, busy=1; md_ready ignored this cycle.
  - Next state BUSY.
- BUSY:
  - stall=1, busy=1; md_a/md_b held stable.
  - On md_ready: capture md_result and md_exception; go to DONE.
- DONE (1 cycle):
  - stall=0, busy=1, wb_valid=1.
  - Exception: wb_rd=30, wb_data=4 (mult) or 5 (div), zero-extended.
  - Otherwise: wb_rd=latched rd, wb_data=captured result.
  - wb_valid still asserts when rd==0; the regfile discards the write.
  - No new accept in DONE: the X instruction is still the completing op. Next state IDLE.
- Latency: accept in cycle N → md_* pulse in N+1 → earliest DONE in N+3. Stall is high from N through the last BUSY cycle.
- Back-to-back ops: the next mul/div is accepted no earlier than the cycle after DONE.
- Flush:
  - In IDLE: suppresses accept.
  - In LAUNCH/BUSY: return to IDLE next cycle, stall drops, no writeback, later md_ready ignored.
  - In DONE: wb_valid forced 0.
- Simultaneous md_ready and flush in BUSY: flush wins.

Optional Feature:
- Macro MULTDIV_TIMEOUT_EN.
- Defined:
  - A counter counts BUSY cycles.
  - Reaching TIMEOUT_CYCLES without md_ready forces DONE, treated as an exception (wb_rd=30, code 4/5).
  - The counter clears on entry to LAUNCH.
- Undefined: no counter logic; BUSY waits indefinitely for md_ready.

Test Plan:
- mul, x_a=6, x_b=7, rd=3; ready after 5 BUSY cycles → one md_mult pulse; stall high 7 cycles; DONE: wb_valid=1, wb_rd=3, wb_data=42.
- div, x_a=1, x_b=0, rd=4; md_exception=1 with ready → wb_rd=30, wb_data=5; no write to r4.
- mul overflow (0x40000000 × 4, exception=1) → wb_rd=30, wb_data=4.
- Flush in 3rd BUSY cycle, then md_ready 2 cycles later → stall low the cycle after flush; wb_valid never asserts.
- reset=0 mid-BUSY → next cycle state IDLE, all outputs 0; subsequent md_ready produces no writeback.
- Two consecutive mul ops → second accepted the cycle after the first's DONE; two wb_valid pulses with correct results. With MULTDIV_TIMEOUT_EN and md_ready held low: DONE after 40 BUSY cycles, wb_rd=30, wb_data=4.
